// File: rtl/ltri_fwd_solver.sv
// Streaming forward-substitution solver for L*y = b with unit lower-triangular L.
// Define LTRI_SAT_EN to saturate y to DATA_LEN bits instead of wrapping.
module ltri_fwd_solver #(
  parameter int DATA_LEN = 34,
  parameter int FRACTION = 16,
  parameter int DIM      = 6
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_start,
  input  logic [DATA_LEN-1:0] i_data,
  output logic                o_ready,
  output logic                o_valid,
  output logic [DATA_LEN-1:0] o_data,
  output logic                o_done
);

  localparam int PW      = 2 * DATA_LEN;
  localparam int ACC_LEN = 2 * DATA_LEN - FRACTION + $clog2(DIM);
  localparam int RW      = $clog2(DIM);
  localparam int CW      = $clog2(DIM + 1);

  typedef enum logic [1:0] {IDLE, RUN, WB, DONE} state_t;

  state_t                     state, state_n;
  logic                       start_q;
  logic        [RW-1:0]       row;
  logic        [CW-1:0]       col;
  logic        [CW-1:0]       row_ext;
  logic        [RW-1:0]       col_idx;
  logic signed [ACC_LEN-1:0]  acc;
  logic signed [DATA_LEN-1:0] y_mem [DIM];
  logic signed [DATA_LEN-1:0] data_s;
  logic signed [PW-1:0]       prod;
  logic signed [ACC_LEN-1:0]  term;
  logic signed [ACC_LEN:0]    diff;
  logic                       accept, is_l, is_b;

  // Reduce b - acc to the output width: clamp or keep the low bits.
  function automatic logic signed [DATA_LEN-1:0] reduce_y(input logic signed [ACC_LEN:0] v);
`ifdef LTRI_SAT_EN
    if (v[ACC_LEN] && !(&v[ACC_LEN:DATA_LEN-1]))
      return {1'b1, {(DATA_LEN-1){1'b0}}};
    else if (!v[ACC_LEN] && (|v[ACC_LEN:DATA_LEN-1]))
      return {1'b0, {(DATA_LEN-1){1'b1}}};
    else
      return DATA_LEN'(v);
`else
    return DATA_LEN'(v);
`endif
  endfunction

  assign data_s  = $signed(i_data);
  assign row_ext = CW'(row);
  assign col_idx = col[RW-1:0];
  assign prod    = PW'(data_s) * PW'(y_mem[col_idx]);
  assign term    = ACC_LEN'(prod >>> FRACTION);
  assign diff    = {{(ACC_LEN + 1 - DATA_LEN){i_data[DATA_LEN-1]}}, i_data} - {acc[ACC_LEN-1], acc};
  assign accept  = (state == RUN) && i_start;
  assign is_l    = accept && (col < row_ext);
  assign is_b    = accept && (col == row_ext + CW'(1));

  always_comb begin
    state_n = state;
    o_ready = 1'b0;
    o_valid = 1'b0;
    o_done  = 1'b0;
    case (state)
      IDLE: if (i_start && !start_q) state_n = RUN;
      RUN: begin
        o_ready = 1'b1;
        if (is_b) state_n = WB;
      end
      WB: begin
        o_valid = 1'b1;
        state_n = (row == RW'(DIM - 1)) ? DONE : RUN;
      end
      DONE: begin
        o_done  = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Edge detector keeps tracking through reset so a held-high i_start never restarts.
  always_ff @(posedge clk) start_q <= i_start;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      row    <= '0;
      col    <= '0;
      acc    <= '0;
      o_data <= '0;
      for (int i = 0; i < DIM; i++) y_mem[i] <= '0;
    end else begin
      state <= state_n;
      if (is_l) acc <= acc + term;
      if (is_b) o_data <= reduce_y(diff);
      else if (accept) col <= col + CW'(1);
      if (state == WB) begin
        y_mem[row] <= $signed(o_data);
        acc        <= '0;
        col        <= '0;
        row        <= (row == RW'(DIM - 1)) ? '0 : row + RW'(1);
      end
    end
  end

endmodule
